// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA geometry, colour and plot-arbiter state definitions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [COLOUR_W-1:0] CLEAR_COLOUR = 3'b000;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin one-hot select with registered priority pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   idx;
    logic [PTR_W-1:0]   win;
    logic               found;
    logic [NUM_REQ-1:0] cand;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return PTR_W'(s);
    endfunction

    // Scan from ptr upward, modulo NUM_REQ; the first set request wins.
    always_comb begin
        idx   = '0;
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = wrap_add(ptr, k);
            if (!found && req[idx]) begin
                found     = 1'b1;
                win       = idx;
                cand[idx] = 1'b1;
            end
        end
        grant = en ? cand : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= wrap_add(win, 1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_plot_arbiter.sv
// ============================================================================
// Module      : vga_plot_arbiter
// Description : Shares the VGA adapter pixel port among requesters and
//               sequences full-screen clears.
// Options     : VGA_ARB_BOUNDS_CHECK_EN - drop off-screen pixels, add oob_err
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_plot_arbiter #(
    parameter int                    NUM_REQ      = 4,
    parameter int                    X_W          = vga_pkg::X_W,
    parameter int                    Y_W          = vga_pkg::Y_W,
    parameter int                    COLOUR_W     = vga_pkg::COLOUR_W,
    parameter int                    SCREEN_W     = vga_pkg::SCREEN_W,
    parameter int                    SCREEN_H     = vga_pkg::SCREEN_H,
    parameter logic [COLOUR_W-1:0]   CLEAR_COLOUR = vga_pkg::CLEAR_COLOUR
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear_start,
    output logic                         clear_busy,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*X_W-1:0]       req_x,
    input  logic [NUM_REQ*Y_W-1:0]       req_y,
    input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
    output logic [NUM_REQ-1:0]           grant,
    output logic [X_W-1:0]               vga_x,
    output logic [Y_W-1:0]               vga_y,
    output logic [COLOUR_W-1:0]          vga_colour,
    output logic                         vga_plot
`ifdef VGA_ARB_BOUNDS_CHECK_EN
    ,
    output logic                         oob_err
`endif
);

    import vga_pkg::*;

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    arb_state_t            state;
    logic [X_W-1:0]        cx;
    logic [Y_W-1:0]        cy;
    logic                  arb_en;
    logic [X_W-1:0]        sel_x;
    logic [Y_W-1:0]        sel_y;
    logic [COLOUR_W-1:0]   sel_colour;

    // Clear wins over a same-cycle request; grants are also masked in reset.
    assign arb_en = reset && (state == IDLE) && !clear_start;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req   (req),
        .grant (grant)
    );

    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_x      = req_x[i*X_W +: X_W];
                sel_y      = req_y[i*Y_W +: Y_W];
                sel_colour = req_colour[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

`ifdef VGA_ARB_BOUNDS_CHECK_EN
    logic sel_oob;
    assign sel_oob = (sel_x > X_LAST) || (sel_y > Y_LAST);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cx         <= '0;
            cy         <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            clear_busy <= 1'b0;
`ifdef VGA_ARB_BOUNDS_CHECK_EN
            oob_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    vga_plot <= 1'b0;
                    if (clear_start) begin
                        state      <= CLEAR;
                        cx         <= '0;
                        cy         <= '0;
                        clear_busy <= 1'b1;
`ifdef VGA_ARB_BOUNDS_CHECK_EN
                        oob_err    <= 1'b0;
`endif
                    end else if (|grant) begin
                        vga_x      <= sel_x;
                        vga_y      <= sel_y;
                        vga_colour <= sel_colour;
`ifdef VGA_ARB_BOUNDS_CHECK_EN
                        // Off-screen pixels are consumed but never reach the adapter.
                        if (sel_oob) begin
                            oob_err <= 1'b1;
                        end else begin
                            vga_plot <= 1'b1;
                        end
`else
                        vga_plot   <= 1'b1;
`endif
                    end
                end
                CLEAR: begin
                    vga_x      <= cx;
                    vga_y      <= cy;
                    vga_colour <= CLEAR_COLOUR;
                    vga_plot   <= 1'b1;
                    if (cx == X_LAST) begin
                        cx <= '0;
                        if (cy == Y_LAST) begin
                            cy         <= '0;
                            state      <= IDLE;
                            clear_busy <= 1'b0;
                        end else begin
                            cy <= cy + 1'b1;
                        end
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
// ============================================================================
// Module      : tb_vga_plot_arbiter
// Description : Self-checking bench for vga_plot_arbiter (grant table,
//               pixel scoreboard, clear sweep, reset abort, bounds option).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_plot_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear_start = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_x = '0;
    logic [27:0] req_y = '0;
    logic [11:0] req_colour = '0;
    logic        clear_busy;
    logic [3:0]  grant;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
`ifdef VGA_ARB_BOUNDS_CHECK_EN
    logic        oob_err;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] grant;
    } vec_t;

    pix_t sb[$];
    vec_t vecs[12];

    vga_plot_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .req         (req),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_colour  (req_colour),
        .grant       (grant),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot)
`ifdef VGA_ARB_BOUNDS_CHECK_EN
        ,
        .oob_err     (oob_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_plot();
        pix_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("plot_valid", {31'd0, vga_plot}, 32'd1);
            chk("plot_x", {24'd0, vga_x}, {24'd0, e.x});
            chk("plot_y", {25'd0, vga_y}, {25'd0, e.y});
            chk("plot_colour", {29'd0, vga_colour}, {29'd0, e.c});
        end else begin
            chk("plot_idle", {31'd0, vga_plot}, 32'd0);
        end
    endtask

    task automatic push_pixel(input logic [3:0] g);
        pix_t p;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) begin
                p.x = req_x[i*8 +: 8];
                p.y = req_y[i*7 +: 7];
                p.c = req_colour[i*3 +: 3];
                sb.push_back(p);
            end
        end
    endtask

    task automatic randomize_data();
        for (int i = 0; i < 4; i++) begin
            req_x[i*8 +: 8]      = 8'($urandom_range(159, 0));
            req_y[i*7 +: 7]      = 7'($urandom_range(119, 0));
            req_colour[i*3 +: 3] = 3'($urandom);
        end
    endtask

    // One clock: drive, check combinational grant, then check the registered pixel.
    task automatic cycle(input logic [3:0] r, input logic [3:0] eg, input bit rnd);
        req = r;
        if (rnd) randomize_data();
        #1;
        chk("grant", {28'd0, grant}, {28'd0, eg});
        if (eg != 4'd0) push_pixel(eg);
        @(posedge clk);
        #1;
        check_plot();
    endtask

    task automatic do_reset();
        req = '0;
        clear_start = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        int first_bad;
        logic [7:0] ex;
        logic [6:0] ey;
        pix_t hold;

        vecs[0]  = '{req: 4'b1111, grant: 4'b0010};
        vecs[1]  = '{req: 4'b1111, grant: 4'b0100};
        vecs[2]  = '{req: 4'b1111, grant: 4'b1000};
        vecs[3]  = '{req: 4'b1111, grant: 4'b0001};
        vecs[4]  = '{req: 4'b0001, grant: 4'b0001};
        vecs[5]  = '{req: 4'b1001, grant: 4'b1000};
        vecs[6]  = '{req: 4'b0110, grant: 4'b0010};
        vecs[7]  = '{req: 4'b0000, grant: 4'b0000};
        vecs[8]  = '{req: 4'b0011, grant: 4'b0001};
        vecs[9]  = '{req: 4'b1100, grant: 4'b0100};
        vecs[10] = '{req: 4'b0101, grant: 4'b0001};
        vecs[11] = '{req: 4'b0000, grant: 4'b0000};

        // Reset state, with all requests high to confirm grant masking.
        req = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_plot", {31'd0, vga_plot}, 32'd0);
        chk("rst_x", {24'd0, vga_x}, 32'd0);
        chk("rst_y", {25'd0, vga_y}, 32'd0);
        chk("rst_colour", {29'd0, vga_colour}, 32'd0);
        chk("rst_busy", {31'd0, clear_busy}, 32'd0);
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_plot();

        // Single requester with fixed data.
        req_x[7:0] = 8'd10;
        req_y[6:0] = 7'd20;
        req_colour[2:0] = 3'b100;
        cycle(4'b0001, 4'b0001, 1'b0);
        cycle(4'b0000, 4'b0000, 1'b1);

        // Round-robin table, starting with ptr at 1.
        for (int v = 0; v < 12; v++) begin
            cycle(vecs[v].req, vecs[v].grant, 1'b1);
        end

        // All four requesting continuously from reset.
        do_reset();
        cycle(4'b1111, 4'b0001, 1'b1);
        cycle(4'b1111, 4'b0010, 1'b1);
        cycle(4'b1111, 4'b0100, 1'b1);
        cycle(4'b1111, 4'b1000, 1'b1);
        cycle(4'b1111, 4'b0001, 1'b1);
        cycle(4'b0000, 4'b0000, 1'b1);

        // Clear colliding with a request: clear wins, request served afterwards.
        randomize_data();
        req = 4'b0010;
        clear_start = 1'b1;
        #1;
        chk("clr_collide_grant", {28'd0, grant}, 32'd0);
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        chk("clr_busy_rise", {31'd0, clear_busy}, 32'd1);
        chk("clr_grant_held", {28'd0, grant}, 32'd0);
        check_plot();
        bad = 0;
        first_bad = -1;
        ex = '0;
        ey = '0;
        for (int k = 0; k < 19200; k++) begin
            @(posedge clk);
            #1;
            if (vga_plot !== 1'b1 || vga_x !== ex || vga_y !== ey || vga_colour !== 3'b000) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (k < 19199 && (clear_busy !== 1'b1 || grant !== 4'b0000)) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (ex == 8'd159) begin
                ex = '0;
                ey = ey + 7'd1;
            end else begin
                ex = ex + 8'd1;
            end
        end
        chk("clr_sweep_bad_pixels", bad, 32'd0);
        if (bad > 0) $display("  first bad clear cycle index %0d", first_bad);
        chk("clr_last_x", {24'd0, vga_x}, 32'd159);
        chk("clr_last_y", {25'd0, vga_y}, 32'd119);
        chk("clr_busy_fall", {31'd0, clear_busy}, 32'd0);
        chk("clr_resume_grant", {28'd0, grant}, 32'd2);
        push_pixel(4'b0010);
        @(posedge clk);
        #1;
        req = '0;
        check_plot();

        // Reset in the middle of a clear sweep.
        clear_start = 1'b1;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        repeat (531) @(posedge clk);
        #1;
        chk("mid_clear_x", {24'd0, vga_x}, 32'd50);
        chk("mid_clear_y", {25'd0, vga_y}, 32'd3);
        chk("mid_clear_plot", {31'd0, vga_plot}, 32'd1);
        req = 4'b1111;
        reset = 1'b0;
        #1;
        chk("abort_plot", {31'd0, vga_plot}, 32'd0);
        chk("abort_x", {24'd0, vga_x}, 32'd0);
        chk("abort_y", {25'd0, vga_y}, 32'd0);
        chk("abort_busy", {31'd0, clear_busy}, 32'd0);
        chk("abort_grant", {28'd0, grant}, 32'd0);
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            cycle(4'b0000, 4'b0000, 1'b1);
            chk("post_abort_busy", {31'd0, clear_busy}, 32'd0);
        end
        cycle(4'b1111, 4'b0001, 1'b1);
        cycle(4'b0000, 4'b0000, 1'b1);

`ifdef VGA_ARB_BOUNDS_CHECK_EN
        // Off-screen request: consumed without a plot, sticky error until clear.
        randomize_data();
        req_x[15:8] = 8'd160;
        req_y[13:7] = 7'd5;
        req = 4'b0010;
        #1;
        chk("oob_grant", {28'd0, grant}, 32'd2);
        @(posedge clk);
        #1;
        chk("oob_no_plot", {31'd0, vga_plot}, 32'd0);
        chk("oob_err_set", {31'd0, oob_err}, 32'd1);
        cycle(4'b0100, 4'b0100, 1'b1);
        chk("oob_err_sticky", {31'd0, oob_err}, 32'd1);
        req = '0;
        clear_start = 1'b1;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        chk("oob_err_cleared", {31'd0, oob_err}, 32'd0);
        do_reset();
`endif

        hold = '0;
        if (sb.size() != 0) hold = sb.pop_front();
        chk("scoreboard_drained", {14'd0, hold}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
